// File: rtl/video_decimator.sv
// rtl/video_decimator.sv - pixel-stream decimator and frame-capture engine for the HDMI receive path
//
// Keeps every H_DIV-th pixel of every V_DIV-th active line and produces a write
// strobe, a row-major linear address and the RGB of each kept pixel.
// Capture is either continuous (every frame) or single shot, armed by i_Arm.
//
// Optional feature macro: VDEC_GRAY_EN
//   When defined, adds o_Gray (luma of the kept pixel) and one more pipeline
//   stage on every output. When undefined, o_Gray does not exist and the
//   output latency is two cycles after the input stage.
//
// Ports
//   i_Clk    pixel clock, all logic on its rising edge
//   i_Rst    synchronous active-high reset
//   i_Hsync  horizontal sync, registered only
//   i_Vsync  vertical sync, active level VS_POL
//   i_Vde    active video
//   i_Data   {R,G,B}, R in the MSBs
//   i_Arm    single-shot request (ignored when CONTINUOUS=1)
//   o_En     write strobe, one per kept pixel
//   o_Addr   linear write address
//   o_R/G/B  kept pixel
//   o_Busy   capture engine not idle
//   o_Done   one-cycle pulse at end of a single-shot capture
//   o_Gray   luma of the kept pixel (VDEC_GRAY_EN only)

module video_decimator #(
  parameter int CW         = 8,
  parameter int IN_W       = 1280,
  parameter int IN_H       = 720,
  parameter int H_DIV      = 4,
  parameter int V_DIV      = 4,
  parameter int ADDR_W     = 24,
  parameter int VS_POL     = 1,
  parameter int CONTINUOUS = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Hsync,
  input  logic              i_Vsync,
  input  logic              i_Vde,
  input  logic [3*CW-1:0]   i_Data,
  input  logic              i_Arm,
  output logic              o_En,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [CW-1:0]     o_R,
  output logic [CW-1:0]     o_G,
  output logic [CW-1:0]     o_B,
  output logic              o_Busy,
  output logic              o_Done
`ifdef VDEC_GRAY_EN
  ,
  output logic [CW-1:0]     o_Gray
`endif
);

  localparam int OUT_W = IN_W / H_DIV;
  localparam int OUT_H = IN_H / V_DIV;
  localparam logic [15:0] OUT_W_C = 16'(OUT_W);
  localparam logic [15:0] OUT_H_C = 16'(OUT_H);
  localparam logic [15:0] HD_M1   = 16'(H_DIV - 1);
  localparam logic [15:0] VD_M1   = 16'(V_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(OUT_W * OUT_H - 1);
  localparam logic VS_ACT = 1'(VS_POL);
  localparam bit   CONT   = (CONTINUOUS != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;

  // Input stage
  logic            vs_r, vs_p, vde_r, vde_p, arm_r, hsync_unused_r;
  logic [3*CW-1:0] data_r;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vs_r           <= 1'b0;
      vs_p           <= 1'b0;
      vde_r          <= 1'b0;
      vde_p          <= 1'b0;
      arm_r          <= 1'b0;
      hsync_unused_r <= 1'b0;
      data_r         <= '0;
    end else begin
      vs_r           <= i_Vsync;
      vs_p           <= vs_r;
      vde_r          <= i_Vde;
      vde_p          <= vde_r;
      arm_r          <= i_Arm;
      hsync_unused_r <= i_Hsync;
      data_r         <= i_Data;
    end
  end

  // Geometry counters
  logic [15:0]       hph, vph, ocol, orow;
  logic [ADDR_W-1:0] addr;
  logic              full;

  logic        fs, line_start, line_end, keep;
  logic [15:0] hph_eff, ocol_eff;

  always_comb begin
    fs         = (vs_r == VS_ACT) && (vs_p != VS_ACT);
    line_start = vde_r && !vde_p;
    line_end   = !vde_r && vde_p;
    // Line start clears the per-line phase in the same cycle the first pixel arrives.
    hph_eff    = line_start ? 16'd0 : hph;
    ocol_eff   = line_start ? 16'd0 : ocol;
    // A frame start always wins over a coincident active pixel.
    keep       = vde_r && !fs && (hph_eff == 16'd0) && (vph == 16'd0) &&
                 (ocol_eff < OUT_W_C) && (orow < OUT_H_C) &&
                 (state == CAPTURE) && !full;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hph  <= '0;
      vph  <= '0;
      ocol <= '0;
      orow <= '0;
      addr <= '0;
      full <= 1'b0;
    end else if (fs) begin
      hph  <= '0;
      vph  <= '0;
      ocol <= '0;
      orow <= '0;
      addr <= '0;
      full <= 1'b0;
    end else begin
      if (vde_r) begin
        hph <= (hph_eff == HD_M1) ? 16'd0 : hph_eff + 16'd1;
        if ((hph_eff == 16'd0) && (ocol_eff < OUT_W_C)) begin
          ocol <= ocol_eff + 16'd1;
        end else begin
          ocol <= ocol_eff;
        end
      end
      if (line_end) begin
        vph <= (vph == VD_M1) ? 16'd0 : vph + 16'd1;
        if ((vph == 16'd0) && (orow < OUT_H_C)) begin
          orow <= orow + 16'd1;
        end
      end
      // The address saturates on LAST; everything after it is dropped until the next frame.
      if (keep) begin
        if (addr == LAST_A) begin
          full <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  // Capture sequencer
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= CONT ? WAIT_VS : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm_r && !CONT) begin
            state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (fs) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!CONT && (fs || (keep && (addr == LAST_A)))) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decision stage; done/busy come from the state register, so they trail the
  // pixel path by one stage, which places o_Done one cycle after the LAST write.
  logic              s2_en, s2_done, s2_busy;
  logic [ADDR_W-1:0] s2_addr;
  logic [3*CW-1:0]   s2_data;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      s2_en   <= 1'b0;
      s2_done <= 1'b0;
      s2_busy <= 1'b0;
      s2_addr <= '0;
      s2_data <= '0;
    end else begin
      s2_en   <= keep;
      s2_done <= (state == DONE);
      s2_busy <= (state != IDLE);
      s2_addr <= addr;
      s2_data <= data_r;
    end
  end

`ifdef VDEC_GRAY_EN
  localparam int GW = CW + 8;

  logic              s3_en, s3_done, s3_busy;
  logic [ADDR_W-1:0] s3_addr;
  logic [3*CW-1:0]   s3_data;
  logic [GW-1:0]     gsum;

  always_comb begin
    gsum = GW'(77)  * GW'(s3_data[3*CW-1:2*CW]) +
           GW'(150) * GW'(s3_data[2*CW-1:CW]) +
           GW'(29)  * GW'(s3_data[CW-1:0]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      s3_en   <= 1'b0;
      s3_done <= 1'b0;
      s3_busy <= 1'b0;
      s3_addr <= '0;
      s3_data <= '0;
      o_En    <= 1'b0;
      o_Addr  <= '0;
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
      o_Gray  <= '0;
    end else begin
      s3_en   <= s2_en;
      s3_done <= s2_done;
      s3_busy <= s2_busy;
      s3_addr <= s2_addr;
      s3_data <= s2_data;
      o_En    <= s3_en;
      o_Addr  <= s3_en ? s3_addr : '0;
      o_R     <= s3_en ? s3_data[3*CW-1:2*CW] : '0;
      o_G     <= s3_en ? s3_data[2*CW-1:CW] : '0;
      o_B     <= s3_en ? s3_data[CW-1:0] : '0;
      o_Busy  <= s3_busy;
      o_Done  <= s3_done;
      o_Gray  <= s3_en ? gsum[GW-1:8] : '0;
    end
  end
`else
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_En   <= 1'b0;
      o_Addr <= '0;
      o_R    <= '0;
      o_G    <= '0;
      o_B    <= '0;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
    end else begin
      o_En   <= s2_en;
      o_Addr <= s2_en ? s2_addr : '0;
      o_R    <= s2_en ? s2_data[3*CW-1:2*CW] : '0;
      o_G    <= s2_en ? s2_data[2*CW-1:CW] : '0;
      o_B    <= s2_en ? s2_data[CW-1:0] : '0;
      o_Busy <= s2_busy;
      o_Done <= s2_done;
    end
  end
`endif

endmodule

// File: tb/tb_video_decimator.sv
// tb/tb_video_decimator.sv - directed bench for video_decimator (continuous, single-shot, H_DIV=3 instances)

module tb_video_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hs, vs, vde, arm;
  logic [23:0] data;

  logic        en   [3];
  logic [23:0] addr [3];
  logic [7:0]  r    [3];
  logic [7:0]  g    [3];
  logic [7:0]  b    [3];
  logic        busy [3];
  logic        done [3];

`ifdef VDEC_GRAY_EN
  logic [7:0] gray [3];
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  video_decimator #(.CW(8), .IN_W(16), .IN_H(8), .H_DIV(2), .V_DIV(2), .ADDR_W(24),
                    .VS_POL(1), .CONTINUOUS(1)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_Hsync(hs), .i_Vsync(vs), .i_Vde(vde), .i_Data(data),
    .i_Arm(arm), .o_En(en[0]), .o_Addr(addr[0]), .o_R(r[0]), .o_G(g[0]), .o_B(b[0]),
    .o_Busy(busy[0]), .o_Done(done[0])
`ifdef VDEC_GRAY_EN
    , .o_Gray(gray[0])
`endif
  );

  video_decimator #(.CW(8), .IN_W(16), .IN_H(8), .H_DIV(2), .V_DIV(2), .ADDR_W(24),
                    .VS_POL(1), .CONTINUOUS(0)) dut_s (
    .i_Clk(clk), .i_Rst(rst), .i_Hsync(hs), .i_Vsync(vs), .i_Vde(vde), .i_Data(data),
    .i_Arm(arm), .o_En(en[1]), .o_Addr(addr[1]), .o_R(r[1]), .o_G(g[1]), .o_B(b[1]),
    .o_Busy(busy[1]), .o_Done(done[1])
`ifdef VDEC_GRAY_EN
    , .o_Gray(gray[1])
`endif
  );

  video_decimator #(.CW(8), .IN_W(12), .IN_H(2), .H_DIV(3), .V_DIV(1), .ADDR_W(24),
                    .VS_POL(1), .CONTINUOUS(1)) dut_h (
    .i_Clk(clk), .i_Rst(rst), .i_Hsync(hs), .i_Vsync(vs), .i_Vde(vde), .i_Data(data),
    .i_Arm(arm), .o_En(en[2]), .o_Addr(addr[2]), .o_R(r[2]), .o_G(g[2]), .o_B(b[2]),
    .o_Busy(busy[2]), .o_Done(done[2])
`ifdef VDEC_GRAY_EN
    , .o_Gray(gray[2])
`endif
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int pix0_cyc = 0;

  int lastd [3] = '{31, 31, 7};
  int cnt [3], seq_err [3], maxa [3], exp_next [3], first_cyc [3], first_addr [3];
  int last_cyc [3], done_cnt [3], done_cyc [3], busy_cnt [3];
  logic        done_p [3];
  logic [23:0] mem [3][64];
  logic [7:0]  gmem [64];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: records what each instance writes, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (en[d]) begin
        if (cnt[d] == 0) begin
          first_cyc[d]  = cyc;
          first_addr[d] = int'(addr[d]);
        end
        if (int'(addr[d]) != exp_next[d]) seq_err[d]++;
        exp_next[d] = int'(addr[d]) + 1;
        if (int'(addr[d]) > maxa[d]) maxa[d] = int'(addr[d]);
        if (addr[d] < 24'd64) mem[d][addr[d][5:0]] = {r[d], g[d], b[d]};
`ifdef VDEC_GRAY_EN
        if (d == 0 && addr[d] < 24'd64) gmem[addr[d][5:0]] = gray[d];
`endif
        if (int'(addr[d]) == lastd[d]) last_cyc[d] = cyc;
        cnt[d]++;
      end
      if (done[d]) begin
        if (!done_p[d]) done_cyc[d] = cyc;
        done_cnt[d]++;
      end
      if (busy[d]) busy_cnt[d]++;
      done_p[d] = done[d];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; seq_err[d] = 0; maxa[d] = 0; exp_next[d] = 0;
      first_cyc[d] = -1; first_addr[d] = -1; last_cyc[d] = -1;
      done_cnt[d] = 0; done_cyc[d] = -1; busy_cnt[d] = 0;
      for (int k = 0; k < 64; k++) mem[d][k] = 24'h0;
    end
    for (int k = 0; k < 64; k++) gmem[k] = 8'h0;
  endtask

  function automatic logic [23:0] tbl_px(input int col);
    case (col)
      0:       tbl_px = 24'hFF0000;
      2:       tbl_px = 24'h00FF00;
      4:       tbl_px = 24'hFFFFFF;
      default: tbl_px = 24'h000000;
    endcase
  endfunction

  // One frame: vsync pulse, then h lines of w active pixels with blanking around them.
  task automatic send_frame(input int w, input int h, input int arm_at, input int rst_at,
                            input bit tbl);
    vde = 1'b0;
    vs  = 1'b1;
    repeat (3) step();
    vs = 1'b0;
    repeat (3) step();
    for (int row = 0; row < h; row++) begin
      hs = 1'b1;
      repeat (3) step();
      hs = 1'b0;
      for (int col = 0; col < w; col++) begin
        int idx;
        idx  = row * w + col;
        vde  = 1'b1;
        data = tbl ? tbl_px(col) : {8'(row), 8'(col), 8'h5A};
        arm  = (idx == arm_at);
        rst  = (idx == rst_at);
        step();
        if (idx == 0) pix0_cyc = cyc;
        if (idx == rst_at) begin
          chk("rst_mid_outputs_c", {en[0], addr[0], r[0], g[0], b[0], busy[0], done[0]}, 64'h0);
          chk("rst_mid_outputs_h", {en[2], addr[2], r[2], g[2], b[2], busy[2], done[2]}, 64'h0);
        end
      end
      vde = 1'b0;
      arm = 1'b0;
      rst = 1'b0;
    end
    repeat (6) step();
  endtask

  task automatic chk_pixels(input int d, input int n, input int ow, input int hdiv, input int vdiv);
    for (int k = 0; k < n; k++) begin
      logic [23:0] e;
      e = {8'(vdiv * (k / ow)), 8'(hdiv * (k % ow)), 8'h5A};
      chk($sformatf("pixel_d%0d_a%0d", d, k), mem[d][k], e);
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vde = 1'b0; arm = 1'b0; data = 24'h0;
    clr();
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_outputs_d%0d", d),
          {en[d], addr[d], r[d], g[d], b[d], busy[d], done[d]}, 64'h0);
    end
    rst = 1'b0;
    repeat (2) step();

    // Frame 1: continuous capture; single-shot armed mid-frame must stay silent.
    clr();
    send_frame(16, 8, 3 * 16 + 5, -1, 1'b0);
    chk("f1_c_count", cnt[0], 32);
    chk("f1_c_seq", seq_err[0], 0);
    chk("f1_c_first_addr", first_addr[0], 0);
    chk("f1_c_max_addr", maxa[0], 31);
    chk("f1_c_latency", first_cyc[0], pix0_cyc + LAT);
    chk("f1_c_no_done", done_cnt[0], 0);
    chk_pixels(0, 32, 8, 2, 2);
    chk("f1_s_no_write", cnt[1], 0);
    chk("f1_s_busy_armed", busy[1], 1);

    // Frame 2: continuous restarts at 0; single shot captures one full frame.
    clr();
    send_frame(16, 8, -1, -1, 1'b0);
    chk("f2_c_count", cnt[0], 32);
    chk("f2_c_first_addr", first_addr[0], 0);
    chk("f2_c_seq", seq_err[0], 0);
    chk("f2_s_count", cnt[1], 32);
    chk("f2_s_seq", seq_err[1], 0);
    chk_pixels(1, 32, 8, 2, 2);
    chk("f2_s_done_once", done_cnt[1], 1);
    chk("f2_s_done_timing", done_cyc[1], last_cyc[1] + 1);
    chk("f2_s_was_busy", busy_cnt[1] > 0, 1);
    chk("f2_s_busy_low", busy[1], 0);

    // Frame 3: single shot is idle again.
    clr();
    send_frame(16, 8, -1, -1, 1'b0);
    chk("f3_s_no_write", cnt[1], 0);
    chk("f3_s_no_done", done_cnt[1], 0);
    chk("f3_c_count", cnt[0], 32);

    // Frame 4: reset just after address 10 is written (pixel row 2, col 7).
    clr();
    send_frame(16, 8, -1, 2 * 16 + 7, 1'b0);
    chk("f4_c_count", cnt[0], 11);
    chk("f4_c_max_addr", maxa[0], 10);
    chk("f4_c_seq", seq_err[0], 0);

    // Frame 5: fresh frame after reset starts at address 0.
    clr();
    send_frame(16, 8, -1, -1, 1'b0);
    chk("f5_c_count", cnt[0], 32);
    chk("f5_c_first_addr", first_addr[0], 0);

    // Frame 6: oversized 20x10 input; extra pixels and lines dropped.
    clr();
    send_frame(20, 10, -1, -1, 1'b0);
    chk("f6_c_count", cnt[0], 32);
    chk("f6_c_max_addr", maxa[0], 31);
    chk("f6_c_seq", seq_err[0], 0);
    chk_pixels(0, 32, 8, 2, 2);

    // Frame 7: H_DIV=3, V_DIV=1 on a 12x2 frame.
    clr();
    send_frame(12, 2, -1, -1, 1'b0);
    chk("f7_h_count", cnt[2], 8);
    chk("f7_h_max_addr", maxa[2], 7);
    chk("f7_h_seq", seq_err[2], 0);
    chk_pixels(2, 8, 4, 3, 1);

`ifdef VDEC_GRAY_EN
    // Frame 8: luma of pure red, pure green and white.
    clr();
    send_frame(16, 1, -1, -1, 1'b1);
    chk("gray_red", gmem[0], 8'd76);
    chk("gray_green", gmem[1], 8'd149);
    chk("gray_white", gmem[2], 8'd255);
    chk("gray_latency", first_cyc[0], pix0_cyc + 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/video_decimator.md
# video_decimator

Parametrised pixel-stream decimator and frame-capture engine for the HDMI receive path. Sits after the DVI-to-RGB decoder in the pixel-clock domain: takes the 24-bit pixel stream with VDE/HSYNC/VSYNC, keeps every H_DIV-th pixel of every V_DIV-th active line, and emits a write strobe, linear BRAM address and RGB for the frame buffer that feeds the Ethernet transmitter. Supports continuous capture or armed single-frame capture with a done pulse.

## Interface
- CW, 8: bits per colour channel
- IN_W, 1280: active pixels per line kept (extra pixels dropped)
- IN_H, 720: active lines per frame kept (extra lines dropped)
- H_DIV, 4: horizontal decimation factor, ≥1
- V_DIV, 4: vertical decimation factor, ≥1
- ADDR_W, 24: address width; must hold (IN_W/H_DIV)*(IN_H/V_DIV)
- VS_POL, 1: active level of i_Vsync
- CONTINUOUS, 1: 1 = capture every frame; 0 = single shot on i_Arm
- i_Clk  in  1  pixel clock; one clock, all logic on its rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Hsync  in  1  horizontal sync (registered, passed nowhere; used for nothing but alignment of the input stage)
- i_Vsync  in  1  vertical sync, level per VS_POL
- i_Vde  in  1  active video
- i_Data  in  3*CW  {R,G,B}, R in MSBs
- i_Arm  in  1  single-shot request; ignored when CONTINUOUS=1
- o_En  out  1  write strobe, one per kept pixel
- o_Addr  out  ADDR_W  linear write address, row-major
- o_R, o_G, o_B  out  CW  kept pixel
- o_Busy  out  1  state ≠ IDLE
- o_Done  out  1  one-cycle pulse at end of single-shot capture
- o_Gray  out  CW  luma (present only with VDEC_GRAY_EN)

## Operation
- OUT_W = IN_W/H_DIV, OUT_H = IN_H/V_DIV (integer division); LAST = OUT_W*OUT_H−1.
- Stage 1 registers all inputs. Frame start (FS) = registered vsync transitioning to VS_POL. Line start = Vde 0→1; line end = Vde 1→0.
- Counters: col (pixels in line), hph 0..H_DIV−1 (cleared at line start), vph 0..V_DIV−1 (advanced at line end, cleared at FS), ocol/orow output coordinates; all cleared at FS.
- Keep pixel iff Vde, hph==0, vph==0, ocol<OUT_W, orow<OUT_H, state==CAPTURE. Kept pixel: write at o_Addr, then address +1. Address never exceeds LAST; further pixels suppressed until FS.
- FS with Vde=1 in same cycle: FS wins, that pixel discarded.
- FSM: IDLE → (i_Arm) WAIT_VS → (FS) CAPTURE → (write of LAST, or FS before LAST) DONE → IDLE. DONE lasts one cycle, drives o_Done.
- CONTINUOUS=1: reset state WAIT_VS; CAPTURE re-enters itself at every FS (address → 0); IDLE/DONE unused; o_Done stays 0.
- i_Arm outside IDLE ignored. FS in the same cycle as entering WAIT_VS is not seen; capture starts at next FS.

## Timing
- Reset: all outputs 0, counters 0, state IDLE (CONTINUOUS=0) or WAIT_VS (CONTINUOUS=1). Reset mid-frame: outputs 0 on the following cycle; no write until a fresh FS; partial frame never resumed.
- Latency: i_Data/i_Vde sampled at edge n → o_En, o_Addr, o_R/G/B valid after edge n+2. With VDEC_GRAY_EN all outputs, including o_Gray, after edge n+3 (aligned).
- o_Done asserted the cycle after the LAST write is presented; o_Busy falls with o_Done.
- o_En high at most one cycle per kept pixel; no back-pressure.

## Configuration
- VDEC_GRAY_EN defined: o_Gray = (77·R + 150·G + 29·B) >> 8, unsigned, width CW+8 internal, truncated to CW; one extra pipeline stage on every output.
- Undefined: no o_Gray port, no multiplier, latency 2.

## Test plan
Base params IN_W=16, IN_H=8, H_DIV=2, V_DIV=2, CW=8 (OUT 8×4, LAST=31); data = {row, col, 8'h5A}.
- CONTINUOUS=1, two frames → 32 o_En per frame, o_Addr 0..31, pixel at addr k = row 2·(k/8), col 2·(k%8); addr restarts at 0 in frame 2.
- CONTINUOUS=0, i_Arm mid-frame → no o_En until next FS; 32 writes; o_Done one cycle after addr-31 write; o_Busy then 0; following frame: zero writes.
- Lines of 20 active pixels, 10 lines → only cols 0..14 even and rows 0..6 even written; exactly 32 writes, address never >31.
- i_Rst for one cycle after addr 10 written → all outputs 0 next cycle, no writes until next FS, first write at addr 0.
- VDEC_GRAY_EN: RGB FF/00/00 → o_Gray 76; 00/FF/00 → 149; FF/FF/FF → 255; latency exactly 3 cycles.
- H_DIV=3, V_DIV=1, IN_W=12, IN_H=2 → 4 writes per line, cols 0,3,6,9; 8 writes total.
